// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues
// request-to-send, then shifts one odd-parity frame out on device clock edges.
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 12000,
   parameter int RTS_CYC     = 200,
   parameter int TIMEOUT_CYC = 1500000
) (
   input  logic       CLK100MHz,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic [2:0] dbg_state_o
);

   localparam int MAX_AB  = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
   localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYC - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_RTS       = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [9:0]    frame_q, frame_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic clk_s1_q, clk_s2_q, clk_s3_q;
   logic dat_s1_q, dat_s2_q;
   logic clk_fall;
   logic in_frame;

   // Synchronizers idle at 1 so reset release never looks like a falling edge.
   always_ff @(posedge CLK100MHz or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_in;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_data_in;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign clk_fall = clk_s3_q & ~clk_s2_q;

   // One counter serves the inhibit hold, then restarts at RTS entry and
   // serves both the RTS hold and the frame timeout until IDLE.
   assign in_frame = (state_q == S_RTS) || (state_q == S_SEND) ||
                     (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            // Handshake: a byte is taken in any cycle where tx_valid and
            // tx_ready are both high; tx_ready is high only in IDLE.
            if (tx_valid) begin
               frame_d  = {1'b1, ~^tx_data, tx_data};
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_RTS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_RTS: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RTS_LAST) begin
               clk_oe_d  = 1'b0;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end
         end

         S_SEND: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               data_oe_d = ~frame_q[bit_cnt_q];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9) begin
                  state_d = S_ACK;
               end
            end
         end

         S_ACK: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               if (!dat_s2_q) begin
                  state_d = S_WAIT_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         S_WAIT_IDLE: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_s2_q && dat_s2_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

      if (in_frame && (cnt_q == TO_LAST)) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b1;
         state_d   = S_IDLE;
      end
   end

   always_ff @(posedge CLK100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 12000, SHALL set the clock-inhibit hold in clock cycles (120 us at 100 MHz).
REQ-002 Parameter RTS_CYC, default 200, SHALL set the hold time with both lines low before clock release.
REQ-003 Parameter TIMEOUT_CYC, default 1500000, SHALL set the frame abort limit (15 ms at 100 MHz).
REQ-004 CLK100MHz  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 tx_data  in  8  SHALL carry the command byte to send to the device.
REQ-007 tx_valid  in  1  SHALL request transmission of tx_data.
REQ-008 tx_ready  out  1  SHALL be high only in IDLE.
REQ-009 tx_done  out  1  SHALL pulse for one cycle on an acknowledged frame.
REQ-010 tx_err  out  1  SHALL pulse for one cycle on NACK or timeout.
REQ-011 ps2_clk_in  in  1  SHALL be the raw PS/2 clock line level.
REQ-012 ps2_data_in  in  1  SHALL be the raw PS/2 data line level.
REQ-013 ps2_clk_oe  out  1  SHALL drive the PS/2 clock line low when 1 and release it when 0.
REQ-014 ps2_data_oe  out  1  SHALL drive the PS/2 data line low when 1 and release it when 0.

Function
REQ-015 Line inputs SHALL pass through 2-flop synchronizers. A clock falling edge is a synced 1->0 transition, detected with one extra flop.
REQ-016 States SHALL be IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe outputs are 0. On tx_valid=1, latch the 10-bit frame {stop=1, odd parity, tx_data}, set ps2_clk_oe=1, clear the cycle counter and enter INHIBIT. tx_valid is ignored in all other states.
REQ-018 INHIBIT: hold ps2_clk_oe=1 for exactly INHIBIT_CYC cycles. Then set ps2_data_oe=1 (start bit) and enter RTS.
REQ-019 RTS: hold both oe outputs at 1 for RTS_CYC cycles. Then set ps2_clk_oe=0, set bit_cnt=0 and enter SEND.
REQ-020 SEND: on each clock falling edge, drive frame bit bit_cnt with ps2_data_oe = NOT bit, then increment bit_cnt.
- bits 0-7 are data, LSB first
- bit 8 is parity, which makes the count of ones across data and parity odd
- bit 9 is the stop bit (data released)
- after bit 9 is driven, enter ACK
REQ-021 ACK: on the next falling edge, sample synced data. 0 -> enter WAIT_IDLE. 1 -> pulse tx_err and enter IDLE.
REQ-022 WAIT_IDLE: when synced clock and data are both 1, pulse tx_done and enter IDLE.
REQ-023 A timeout counter SHALL start on entry to RTS and run until return to IDLE. When it reaches TIMEOUT_CYC, release both lines, pulse tx_err and enter IDLE, overriding any other transition in that cycle.
REQ-024 tx_done and tx_err SHALL never be asserted in the same cycle.
REQ-025 ps2_clk_oe SHALL never be 1 in SEND, ACK or WAIT_IDLE.
REQ-026 ps2_data_oe SHALL be 0 in IDLE, ACK and WAIT_IDLE.
REQ-027 Counters SHALL be sized to hold TIMEOUT_CYC without wrap-around.
REQ-028 Extra falling edges after the stop bit, before ACK sampling, SHALL not occur by protocol. If they do, only the first is used.

Reset
REQ-029 While reset_n=0, outputs SHALL be held immediately (asynchronously) at: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, and synchronizer flops at 1.
REQ-030 tx_ready SHALL be 1 from the first cycle after reset_n rises.
REQ-031 Reset asserted mid-frame SHALL release both lines at once, with no tx_done or tx_err pulse.

Verification
REQ-032 Send 0xED to a device model (10 kHz clocks, ACK low):
- data driven 1,0,1,1,0,1,1,1
- parity 1, then stop released
- tx_done pulses once; tx_err stays 0
REQ-033 Send 0x00:
- 8 zero bits, parity 1
- ps2_clk_oe high exactly INHIBIT_CYC cycles before ps2_data_oe rises
- clock released RTS_CYC cycles later
REQ-034 Device leaves data high at the ACK edge -> tx_err pulses once, tx_done stays 0, both oe outputs are 0.
REQ-035 No device clocks after RTS -> tx_err exactly TIMEOUT_CYC cycles after RTS entry, lines released, tx_ready=1 the next cycle.
REQ-036 Pulse reset_n low after 4 data bits -> oe outputs drop to 0 asynchronously. A new 0xF4 transmission then completes with tx_done.
REQ-037 Pulse tx_valid with 0xFF during SEND -> ignored; the current frame completes unchanged with a single tx_done.
